// File: rtl/fifo_write_arbiter_pkg.sv
// Shared types and helpers for the fifo write-port arbiter.
// clogb2 matches the async fifo's width helper so index and count widths line up.
package fifo_write_arbiter_pkg;

   typedef enum logic {
      ARB_IDLE  = 1'b0,
      ARB_OWNED = 1'b1
   } arb_state_e;

   function automatic int clogb2(input int value);
      int v;
      int r;
      v = value;
      r = 0;
      while (v > 0) begin
         r = r + 1;
         v = v >> 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/fifo_rr_pick.sv
// Round-robin picker: first set request strictly after ptr, wrapping modulo NUM_REQ.
// ptr itself is searched last, so the previous owner has lowest priority.
module fifo_rr_pick
   import fifo_write_arbiter_pkg::*;
#(
   parameter  int NUM_REQ   = 4,
   localparam int IDX_WIDTH = clogb2(NUM_REQ - 1)
) (
   input  logic [NUM_REQ-1:0]   req,
   input  logic [IDX_WIDTH-1:0] ptr,
   output logic                 any,
   output logic [IDX_WIDTH-1:0] idx
);

   logic [IDX_WIDTH-1:0] cand;

   // Walk from the farthest candidate to the nearest so the nearest hit wins.
   always_comb begin
      any  = 1'b0;
      idx  = '0;
      cand = '0;
      for (int k = NUM_REQ; k >= 1; k--) begin
         cand = IDX_WIDTH'((int'(ptr) + k) % NUM_REQ);
         if (req[cand]) begin
            any = 1'b1;
            idx = cand;
         end
      end
   end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Packet-atomic round-robin arbiter sharing one async fifo write port among NUM_REQ producers.
// The owner keeps the port until its last beat (or the MAX_BURST cap) is accepted.
module fifo_write_arbiter
   import fifo_write_arbiter_pkg::*;
#(
   parameter  int NUM_REQ    = 4,
   parameter  int DATA_WIDTH = 32,
   parameter  int MAX_BURST  = 64,
   localparam int IDX_WIDTH  = clogb2(NUM_REQ - 1)
) (
   input  logic                          clock_in,
   input  logic                          rst_in_n,
   input  logic [NUM_REQ-1:0]            req_valid,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
   input  logic [NUM_REQ-1:0]            req_last,
   output logic [NUM_REQ-1:0]            req_ack,
   output logic [DATA_WIDTH-1:0]         fifo_data,
   output logic                          fifo_valid,
   input  logic                          fifo_full,
   output logic [NUM_REQ-1:0]            grant,
   output logic                          burst_error
);

   localparam int CNT_W = (clogb2(MAX_BURST) > 0) ? clogb2(MAX_BURST) : 1;

   arb_state_e           state_q;
   logic [IDX_WIDTH-1:0] g_q;
   logic [IDX_WIDTH-1:0] rr_q;
   logic [CNT_W-1:0]     cnt_q;
   logic [CNT_W-1:0]     cnt_d;
   logic [CNT_W:0]       cnt_inc;
   logic [NUM_REQ-1:0]   grant_q;
   logic                 err_q;

   logic                 owned;
   logic [IDX_WIDTH-1:0] pick_ptr;
   logic [IDX_WIDTH-1:0] pick_idx;
   logic                 pick_any;
   logic [IDX_WIDTH-1:0] sel;
   logic                 accept;
   logic                 last_beat;
   logic                 cap_hit;
   logic                 release_ev;

   assign owned = (state_q == ARB_OWNED);

   // One picker serves both the idle pick (from rr) and the release re-pick (from the owner).
   assign pick_ptr = owned ? g_q : rr_q;

   fifo_rr_pick #(
      .NUM_REQ (NUM_REQ)
   ) u_pick (
      .req (req_valid),
      .ptr (pick_ptr),
      .any (pick_any),
      .idx (pick_idx)
   );

   assign sel        = owned ? g_q : '0;
   assign fifo_data  = req_data[int'(sel)*DATA_WIDTH +: DATA_WIDTH];
   assign fifo_valid = owned & req_valid[g_q];
   assign accept     = fifo_valid & ~fifo_full;
   assign req_ack    = accept ? (NUM_REQ'(1) << g_q) : '0;

   assign last_beat  = req_last[g_q];
   assign cnt_inc    = {1'b0, cnt_q} + (CNT_W + 1)'(1);
   assign cap_hit    = (MAX_BURST > 0) && (cnt_inc == (CNT_W + 1)'(MAX_BURST));
   assign release_ev = accept & (last_beat | cap_hit);
   assign cnt_d      = release_ev ? '0 : (accept ? cnt_inc[CNT_W-1:0] : cnt_q);

   assign grant       = grant_q;
   assign burst_error = err_q;

   always_ff @(posedge clock_in or negedge rst_in_n) begin
      if (!rst_in_n) begin
         state_q <= ARB_IDLE;
         g_q     <= '0;
         rr_q    <= IDX_WIDTH'(NUM_REQ - 1);
         cnt_q   <= '0;
         grant_q <= '0;
         err_q   <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         case (state_q)
            ARB_IDLE: begin
               if (pick_any) begin
                  state_q <= ARB_OWNED;
                  g_q     <= pick_idx;
                  grant_q <= NUM_REQ'(1) << pick_idx;
               end
            end
            ARB_OWNED: begin
               // Hand over on release without an idle bubble when someone is waiting.
               if (release_ev) begin
                  rr_q <= g_q;
                  if (cap_hit && !last_beat) begin
                     err_q <= 1'b1;
                  end
                  if (pick_any) begin
                     g_q     <= pick_idx;
                     grant_q <= NUM_REQ'(1) << pick_idx;
                  end else begin
                     state_q <= ARB_IDLE;
                     grant_q <= '0;
                  end
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Bench for fifo_write_arbiter: scripted producers, a behavioural arbiter model
// checked every cycle, and literal expectations on accepted beat order.
module tb_fifo_write_arbiter;

   localparam int N  = 4;
   localparam int DW = 32;
   localparam int MB = 4;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [N-1:0]    req_valid;
   logic [N*DW-1:0] req_data;
   logic [N-1:0]    req_last;
   logic [N-1:0]    req_ack;
   logic [DW-1:0]   fifo_data;
   logic            fifo_valid;
   logic            fifo_full;
   logic [N-1:0]    grant;
   logic            burst_error;

   always #5 clk = ~clk;

   fifo_write_arbiter #(
      .NUM_REQ    (N),
      .DATA_WIDTH (DW),
      .MAX_BURST  (MB)
   ) dut (
      .clock_in    (clk),
      .rst_in_n    (rst_n),
      .req_valid   (req_valid),
      .req_data    (req_data),
      .req_last    (req_last),
      .req_ack     (req_ack),
      .fifo_data   (fifo_data),
      .fifo_valid  (fifo_valid),
      .fifo_full   (fifo_full),
      .grant       (grant),
      .burst_error (burst_error)
   );

   int n_vec = 0;
   int n_mis = 0;
   int cyc = 0;
   int fs = -100;
   int fe = -100;
   logic rst_next;
   logic [N-1:0] ack_s;

   // producer scripts
   int rem[N], plen[N], npk[N], seq[N], dly[N], gap_beat[N], gap_len[N], bip[N];
   bit nolast[N];

   logic [DW-1:0] acc_q[$];
   int            acc_cyc[$];
   logic [DW-1:0] exp_q[$];

   // model state
   int m_owner, m_rr, m_cnt;
   bit m_err;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_mis++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic bitat(input logic [N-1:0] v, input int j);
      logic [N-1:0] t;
      t = v >> j;
      return t[0];
   endfunction

   function automatic logic [DW-1:0] slice(input int j);
      logic [N*DW-1:0] t;
      t = req_data >> (j * DW);
      return t[DW-1:0];
   endfunction

   function automatic int pick(input int p);
      for (int k = 1; k <= N; k++) begin
         int j;
         j = (p + k) % N;
         if (bitat(req_valid, j)) return j;
      end
      return -1;
   endfunction

   // Model of the arbitration rules, compared against the DUT every cycle.
   always @(negedge clk) begin : model_cmp
      logic [N-1:0]  eg;
      logic [N-1:0]  ea;
      logic          ev;
      logic [DW-1:0] ed;
      logic          acc;
      logic          lb;
      logic          cap;
      if (!rst_n) begin
         m_owner = -1;
         m_rr    = N - 1;
         m_cnt   = 0;
         m_err   = 1'b0;
      end
      eg  = '0;
      ea  = '0;
      ev  = 1'b0;
      ed  = slice(0);
      acc = 1'b0;
      if (rst_n && m_owner >= 0) begin
         eg  = N'(1) << m_owner;
         ev  = bitat(req_valid, m_owner);
         ed  = slice(m_owner);
         acc = ev & ~fifo_full;
         if (acc) ea = eg;
      end
      chk("grant", 64'(grant), 64'(eg));
      chk("req_ack", 64'(req_ack), 64'(ea));
      chk("fifo_valid", 64'(fifo_valid), 64'(ev));
      chk("fifo_data", 64'(fifo_data), 64'(ed));
      chk("burst_error", 64'(burst_error), 64'(m_err));
      if (rst_n && req_ack != '0) begin
         acc_q.push_back(fifo_data);
         acc_cyc.push_back(cyc);
      end
      if (rst_n) begin
         if (m_owner < 0) begin
            m_owner = pick(m_rr);
         end else if (acc) begin
            m_cnt++;
            lb  = bitat(req_last, m_owner);
            cap = (MB > 0) && (m_cnt == MB);
            if (lb || cap) begin
               if (cap && !lb) m_err = 1'b1;
               m_rr    = m_owner;
               m_cnt   = 0;
               m_owner = pick(m_rr);
            end
         end
      end
   end

   task automatic drive();
      logic [N-1:0]    v;
      logic [N-1:0]    l;
      logic [N*DW-1:0] d;
      v = '0;
      l = '0;
      d = '0;
      for (int i = 0; i < N; i++) begin
         if (rem[i] > 0 && dly[i] == 0 && !(bip[i] == gap_beat[i] && gap_len[i] > 0))
            v = v | (N'(1) << i);
         if (rem[i] == 1 && !nolast[i])
            l = l | (N'(1) << i);
         d = d | ((N*DW)'(DW'((i << 8) | seq[i])) << (i * DW));
      end
      req_valid = v;
      req_last  = l;
      req_data  = d;
   endtask

   task automatic step();
      @(posedge clk);
      for (int i = 0; i < N; i++) begin
         if (bitat(ack_s, i)) begin
            seq[i]++;
            bip[i]++;
            rem[i]--;
            if (rem[i] == 0) begin
               npk[i]--;
               if (npk[i] > 0) begin
                  rem[i] = plen[i];
                  bip[i] = 0;
               end
            end
         end else if (dly[i] > 0) begin
            dly[i]--;
         end else if (rem[i] > 0 && bip[i] == gap_beat[i] && gap_len[i] > 0) begin
            gap_len[i]--;
         end
      end
      #1;
      if (!rst_n) cyc = -1;
      cyc++;
      rst_n = rst_next;
      fifo_full = (cyc >= fs && cyc < fe);
      drive();
      @(negedge clk);
      ack_s = req_ack;
   endtask

   task automatic prod(input int i, input int len, input int pkts, input int d, input bit nl);
      plen[i]   = len;
      npk[i]    = pkts;
      rem[i]    = (pkts > 0) ? len : 0;
      bip[i]    = 0;
      dly[i]    = d;
      nolast[i] = nl;
   endtask

   task automatic begin_test();
      rst_next = 1'b0;
      for (int i = 0; i < N; i++) begin
         rem[i] = 0; plen[i] = 0; npk[i] = 0; seq[i] = 0; dly[i] = 0;
         gap_beat[i] = -1; gap_len[i] = 0; bip[i] = 0; nolast[i] = 1'b0;
      end
      fs = -100;
      fe = -100;
      step();
      acc_q.delete();
      acc_cyc.delete();
   endtask

   task automatic release_rst();
      step();
      rst_next = 1'b1;
      step();
   endtask

   task automatic check_acc(input string name);
      int n;
      chk({name, "_count"}, 64'(acc_q.size()), 64'(exp_q.size()));
      n = (acc_q.size() < exp_q.size()) ? acc_q.size() : exp_q.size();
      for (int i = 0; i < n; i++)
         chk($sformatf("%s[%0d]", name, i), 64'(acc_q[i]), 64'(exp_q[i]));
   endtask

   initial begin
      int span;
      rst_n = 1'b0;
      rst_next = 1'b0;
      req_valid = '0;
      req_last = '0;
      req_data = '0;
      fifo_full = 1'b0;
      ack_s = '0;

      // 1: producers 1 and 2, single-beat packets, alternate starting with 1
      begin_test();
      prod(1, 1, 3, 0, 1'b0);
      prod(2, 1, 3, 0, 1'b0);
      release_rst();
      chk("t1_no_ack_first_cycle", 64'(req_ack), 64'(0));
      chk("t1_no_grant_first_cycle", 64'(grant), 64'(0));
      step();
      chk("t1_first_ack", 64'(req_ack), 64'(4'b0010));
      chk("t1_first_grant", 64'(grant), 64'(4'b0010));
      repeat (8) step();
      exp_q = '{32'h100, 32'h200, 32'h101, 32'h201, 32'h102, 32'h202};
      check_acc("t1_order");

      // 2: two 3-beat packets, no interleave, no bubble
      begin_test();
      prod(0, 3, 1, 0, 1'b0);
      prod(3, 3, 1, 0, 1'b0);
      release_rst();
      repeat (10) step();
      exp_q = '{32'h000, 32'h001, 32'h002, 32'h300, 32'h301, 32'h302};
      check_acc("t2_order");
      span = (acc_cyc.size() >= 6) ? (acc_cyc[5] - acc_cyc[0]) : -1;
      chk("t2_back_to_back_span", 64'(span), 64'(5));

      // 3: owner 2 stalled by fifo_full for 5 cycles; 4-beat packet ends exactly at cap
      begin_test();
      prod(2, 4, 1, 0, 1'b0);
      prod(1, 1, 1, 3, 1'b0);
      fs = 3;
      fe = 8;
      release_rst();
      repeat (5) step();
      chk("t3_full_grant", 64'(grant), 64'(4'b0100));
      chk("t3_full_valid", 64'(fifo_valid), 64'(1));
      chk("t3_full_ack", 64'(req_ack), 64'(0));
      repeat (8) step();
      exp_q = '{32'h200, 32'h201, 32'h202, 32'h203, 32'h100};
      check_acc("t3_order");
      chk("t3_no_burst_error", 64'(burst_error), 64'(0));

      // 4: producer 1 never sets last, forced release every MAX_BURST beats
      begin_test();
      prod(0, 1, 1, 0, 1'b0);
      prod(1, 8, 1, 0, 1'b1);
      prod(2, 1, 1, 0, 1'b0);
      release_rst();
      repeat (16) step();
      exp_q = '{32'h000, 32'h100, 32'h101, 32'h102, 32'h103, 32'h200,
                32'h104, 32'h105, 32'h106, 32'h107};
      check_acc("t4_order");
      chk("t4_burst_error", 64'(burst_error), 64'(1));

      // 5: owner 3 drops valid for 3 cycles while producer 0 waits
      begin_test();
      prod(3, 3, 1, 0, 1'b0);
      gap_beat[3] = 1;
      gap_len[3] = 3;
      prod(0, 1, 1, 4, 1'b0);
      release_rst();
      repeat (3) step();
      chk("t5_gap_grant", 64'(grant), 64'(4'b1000));
      chk("t5_gap_ack", 64'(req_ack), 64'(0));
      chk("t5_gap_valid", 64'(fifo_valid), 64'(0));
      repeat (8) step();
      exp_q = '{32'h300, 32'h301, 32'h302, 32'h000};
      check_acc("t5_order");

      // 6: reset pulsed while producer 3 owns the port
      begin_test();
      prod(3, 3, 1, 0, 1'b0);
      prod(0, 1, 1, 3, 1'b0);
      fs = 2;
      fe = 3;
      release_rst();
      step();
      step();
      chk("t6_pre_reset_valid", 64'(fifo_valid), 64'(1));
      #2;
      rst_n = 1'b0;
      rst_next = 1'b0;
      ack_s = '0;
      #1;
      chk("t6_reset_grant", 64'(grant), 64'(0));
      chk("t6_reset_valid", 64'(fifo_valid), 64'(0));
      chk("t6_reset_ack", 64'(req_ack), 64'(0));
      fs = -100;
      fe = -100;
      release_rst();
      step();
      chk("t6_producer0_first", 64'(grant), 64'(4'b0001));
      repeat (8) step();
      exp_q = '{32'h300, 32'h000, 32'h301, 32'h302};
      check_acc("t6_order");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
      $finish;
   end

endmodule
